// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit LFSR generator and checker.
// Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  // feedback taps: bits 15, 13, 12, 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the incoming
// sequence, flywheels once locked and counts mismatching beats.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_state,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic              lock_lost,
  output logic [15:0]       err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_COUNT);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [MW-1:0]     match_q, match_d, match_inc;
  logic [LW-1:0]     miss_q, miss_d, miss_inc;
  logic [15:0]       err_q, err_d;
  logic              locked_q, pulse_q, lost_q;
  logic              pulse_d, lost_d;
  logic              hit, nz, bad;

  assign hit       = (in_state == pred_q);
  assign nz        = |in_state;
  assign match_inc = match_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;
  assign bad       = in_valid && (state_q == LOCKED) && !hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
      pulse_q  <= pulse_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (nz) begin
            pred_d  = lfsr_next(in_state);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            pred_d  = lfsr_next(in_state);
            match_d = match_inc;
            if (match_inc == LOCK_MAX) begin
              miss_d  = '0;
              state_d = LOCKED;
            end
          end else if (nz) begin
            pred_d  = lfsr_next(in_state);
            match_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // flywheel: the input never re-seeds the prediction here
          pred_d = lfsr_next(pred_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            miss_d = miss_inc;
            if (miss_inc == LOSS_MAX) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    pulse_d = bad;
    lost_d  = bad && (miss_inc == LOSS_MAX);
    err_d   = err_q;
    // an error landing with a clear survives as a count of one
    if (bad) begin
      if (clear_cnt) begin
        err_d = 16'd1;
      end else if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
    end else if (clear_cnt) begin
      err_d = '0;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign lock_lost = lost_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, errors, loss,
// hunting, clear/saturation and asynchronous reset.
`timescale 1ns/100ps
module tb_lfsr_checker;
  import lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_state;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic        lock_lost;
  logic [15:0] err_count;

  int npass = 0;
  int ntot  = 0;
  logic [15:0] cur;

  lfsr_checker dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_state  (in_state),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .lock_lost (lock_lost),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nx(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic drive(input logic v, input logic [15:0] s,
                       input logic c);
    in_valid  = v;
    in_state  = s;
    clear_cnt = c;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    clear_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ntot++;
    if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked);
    else npass++;
    ntot++;
    if (err_pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", err_pulse);
    else npass++;
    ntot++;
    if (lock_lost !== 1'b0) $display("FAIL reset_lost got %b want 0", lock_lost);
    else npass++;
    ntot++;
    if (err_count !== 16'h0) $display("FAIL reset_cnt got %h want 0000", err_count);
    else npass++;
    reset = 1'b1;
  endtask

  task automatic test_clean_lock;
    cur = 16'hACE1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, cur, 1'b0);
      if (i == 2) begin
        ntot++;
        if (cur !== 16'h59C3) $display("FAIL clean_seq got %h want 59c3", cur);
        else npass++;
      end
      cur = nx(cur);
      ntot++;
      if (locked !== (i >= 5))
        $display("FAIL clean_locked beat %0d got %b want %b", i, locked, i >= 5);
      else npass++;
      ntot++;
      if (err_pulse !== 1'b0 || lock_lost !== 1'b0)
        $display("FAIL clean_pulses beat %0d got %b%b want 00", i, err_pulse, lock_lost);
      else npass++;
    end
    ntot++;
    if (err_count !== 16'h0) $display("FAIL clean_cnt got %h want 0000", err_count);
    else npass++;
  endtask

  task automatic test_single_error;
    drive(1'b1, cur ^ 16'h0001, 1'b0);
    cur = nx(cur);
    ntot++;
    if (err_pulse !== 1'b1) $display("FAIL single_pulse got %b want 1", err_pulse);
    else npass++;
    ntot++;
    if (err_count !== 16'd1) $display("FAIL single_cnt got %h want 0001", err_count);
    else npass++;
    ntot++;
    if (locked !== 1'b1) $display("FAIL single_locked got %b want 1", locked);
    else npass++;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, cur, 1'b0);
      cur = nx(cur);
      ntot++;
      if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1)
        $display("FAIL single_after beat %0d got p=%b c=%h l=%b want p=0 c=0001 l=1",
                 i, err_pulse, err_count, locked);
      else npass++;
    end
    drive(1'b0, 16'h0, 1'b0);
    ntot++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1)
      $display("FAIL idle_cycle got p=%b c=%h want p=0 c=0001", err_pulse, err_count);
    else npass++;
  endtask

  task automatic test_loss_of_lock;
    logic [15:0] x;
    drive(1'b0, 16'h0, 1'b1);
    ntot++;
    if (err_count !== 16'h0) $display("FAIL loss_clear got %h want 0000", err_count);
    else npass++;
    for (int k = 1; k <= 8; k++) begin
      x = 16'($urandom);
      if (x == cur || x == 16'h0) x = cur ^ 16'h0100;
      drive(1'b1, x, 1'b0);
      cur = nx(cur);
      ntot++;
      if (err_pulse !== 1'b1 || err_count !== 16'(k))
        $display("FAIL loss_err beat %0d got p=%b c=%h want p=1 c=%h",
                 k, err_pulse, err_count, 16'(k));
      else npass++;
      ntot++;
      if (lock_lost !== (k == 8) || locked !== (k < 8))
        $display("FAIL loss_state beat %0d got lost=%b l=%b want lost=%b l=%b",
                 k, lock_lost, locked, k == 8, k < 8);
      else npass++;
    end
    cur = 16'h1234;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, cur, 1'b0);
      cur = nx(cur);
      ntot++;
      if (locked !== (i == 5) || lock_lost !== 1'b0)
        $display("FAIL relock beat %0d got l=%b lost=%b want l=%b lost=0",
                 i, locked, lock_lost, i == 5);
      else npass++;
    end
  endtask

  task automatic test_hunt;
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 16'h0000, 1'b0);
    ntot++;
    if (dut.state_q !== HUNT) $display("FAIL hunt_zero got %0d want HUNT", dut.state_q);
    else npass++;
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2223, 1'b0);
    drive(1'b1, 16'h0000, 1'b0);
    ntot++;
    if (dut.state_q !== HUNT) $display("FAIL hunt_zero_verify got %0d want HUNT", dut.state_q);
    else npass++;
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2223, 1'b0);
    drive(1'b0, 16'h4447, 1'b0);
    drive(1'b1, 16'h2222, 1'b0);
    ntot++;
    if (locked !== 1'b0 || err_pulse !== 1'b0)
      $display("FAIL hunt_reseed got l=%b p=%b want 0 0", locked, err_pulse);
    else npass++;
    cur = nx(16'h2222);
    for (int i = 2; i <= 5; i++) begin
      drive(1'b1, cur, 1'b0);
      cur = nx(cur);
      if (i == 3) drive(1'b0, 16'h0, 1'b0);
      ntot++;
      if (locked !== (i == 5))
        $display("FAIL hunt_lock beat %0d got %b want %b", i, locked, i == 5);
      else npass++;
    end
    ntot++;
    if (err_count !== 16'h0) $display("FAIL hunt_cnt got %h want 0000", err_count);
    else npass++;
  endtask

  task automatic test_clear_sat;
    drive(1'b1, cur ^ 16'h0001, 1'b0);
    cur = nx(cur);
    drive(1'b1, cur ^ 16'h0001, 1'b0);
    cur = nx(cur);
    ntot++;
    if (err_count !== 16'd2) $display("FAIL pre_clear got %h want 0002", err_count);
    else npass++;
    drive(1'b1, cur, 1'b0);
    cur = nx(cur);
    drive(1'b1, cur ^ 16'h0001, 1'b1);
    cur = nx(cur);
    ntot++;
    if (err_count !== 16'd1 || err_pulse !== 1'b1)
      $display("FAIL clear_collide got c=%h p=%b want c=0001 p=1", err_count, err_pulse);
    else npass++;
    drive(1'b1, cur, 1'b0);
    cur = nx(cur);
    force dut.err_q = 16'hFFFE;
    #1 release dut.err_q;
    drive(1'b1, cur, 1'b0);
    cur = nx(cur);
    ntot++;
    if (err_count !== 16'hFFFE) $display("FAIL sat_preset got %h want fffe", err_count);
    else npass++;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, cur ^ 16'h0001, 1'b0);
      cur = nx(cur);
      ntot++;
      if (err_count !== 16'hFFFF || locked !== 1'b1)
        $display("FAIL sat beat %0d got c=%h l=%b want c=ffff l=1", k, err_count, locked);
      else npass++;
    end
  endtask

  task automatic test_reset_mid;
    #2 reset = 1'b0;
    #0.5;
    ntot++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || lock_lost !== 1'b0)
      $display("FAIL rst_mid_flags got l=%b p=%b lost=%b want 0 0 0",
               locked, err_pulse, lock_lost);
    else npass++;
    ntot++;
    if (err_count !== 16'h0) $display("FAIL rst_mid_cnt got %h want 0000", err_count);
    else npass++;
    ntot++;
    if (dut.state_q !== HUNT || dut.pred_q !== 16'h0)
      $display("FAIL rst_mid_state got s=%0d pred=%h want HUNT 0000", dut.state_q, dut.pred_q);
    else npass++;
    #0.5 reset = 1'b1;
    @(posedge clk);
    #1;
    cur = 16'hBEEF;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, cur, 1'b0);
      cur = nx(cur);
      ntot++;
      if (locked !== (i == 5))
        $display("FAIL rst_relock beat %0d got %b want %b", i, locked, i == 5);
      else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_hunt();
    test_clear_sat();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
